// File: rtl/bcd_updown_cnt_n.sv
// rtl/bcd_updown_cnt_n.sv - parametrised N-digit BCD up/down counter with load, saturate/wrap and limit pulses
module bcd_updown_cnt_n #(
  parameter int DIGITS = 2,
  parameter bit WRAP   = 1'b0
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  en,
  input  logic                  inc,
  input  logic                  dec,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   count,
  output logic                  at_max,
  output logic                  at_min,
  output logic                  ovf,
  output logic                  unf
);

  localparam int W = 4 * DIGITS;

  logic [W-1:0] count_q, count_d;
  logic [W-1:0] inc_val, dec_val, load_clamped;
  logic         ovf_q, ovf_d;
  logic         unf_q, unf_d;
  logic         inc_carry, dec_borrow;
  logic         all_nine;
  logic         inc_req, dec_req;

  // Simultaneous inc and dec cancel out; en gates both but never load.
  assign inc_req = en & inc & ~dec;
  assign dec_req = en & dec & ~inc;

  // Ripple BCD +1: a 9 rolls to 0 and passes the carry up, the first non-9 digit absorbs it.
  always_comb begin
    inc_val   = count_q;
    inc_carry = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (inc_carry) begin
        if (count_q[4*i +: 4] == 4'd9) begin
          inc_val[4*i +: 4] = 4'd0;
        end else begin
          inc_val[4*i +: 4] = count_q[4*i +: 4] + 4'd1;
          inc_carry         = 1'b0;
        end
      end
    end
  end

  // Ripple BCD -1: a 0 rolls to 9 and passes the borrow up, the first non-zero digit absorbs it.
  always_comb begin
    dec_val    = count_q;
    dec_borrow = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (dec_borrow) begin
        if (count_q[4*i +: 4] == 4'd0) begin
          dec_val[4*i +: 4] = 4'd9;
        end else begin
          dec_val[4*i +: 4] = count_q[4*i +: 4] - 4'd1;
          dec_borrow        = 1'b0;
        end
      end
    end
  end

  // Clamp each load digit to 9 so no non-BCD value can enter the register.
  always_comb begin
    load_clamped = load_val;
    for (int i = 0; i < DIGITS; i++) begin
      if (load_val[4*i +: 4] > 4'd9) begin
        load_clamped[4*i +: 4] = 4'd9;
      end
    end
  end

  // Decode the all-nines limit from the count register.
  always_comb begin
    all_nine = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (count_q[4*i +: 4] != 4'd9) begin
        all_nine = 1'b0;
      end
    end
  end

  // Next-state selection in priority order load > inc > dec > hold; pulses default low every edge.
  always_comb begin
    count_d = count_q;
    ovf_d   = 1'b0;
    unf_d   = 1'b0;
    if (load) begin
      count_d = load_clamped;
    end else if (inc_req) begin
      if (all_nine) begin
        ovf_d = 1'b1;
        if (WRAP) begin
          count_d = '0;
        end
      end else begin
        count_d = inc_val;
      end
    end else if (dec_req) begin
      if (count_q == '0) begin
        unf_d = 1'b1;
        if (WRAP) begin
          for (int i = 0; i < DIGITS; i++) begin
            count_d[4*i +: 4] = 4'd9;
          end
        end
      end else begin
        count_d = dec_val;
      end
    end
  end

  // State register; clr overrides every other request on the same edge.
  always_ff @(posedge clk) begin
    if (clr) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign count  = count_q;
  assign at_max = all_nine;
  assign at_min = (count_q == '0);
  assign ovf    = ovf_q;
  assign unf    = unf_q;

endmodule

// File: doc/bcd_updown_cnt_n.md
Name: bcd_updown_cnt_n

Overview:
Parametrised N-digit BCD up/down counter. It replaces the fixed two-digit inc/dec counter in the lab datapath. Adds a digit-count parameter, a selectable saturate/wrap mode, a parallel BCD load, a count enable, and overflow/underflow pulses. It feeds the 7-segment display drivers and the scoreboard/timer logic.

Parameters:
DIGITS, 2, number of BCD digits; legal range 1..8; counter range 0 .. 10^DIGITS-1
WRAP, 0, 0 = saturate at the limits; 1 = wrap around at the limits (99..9 <-> 00..0)

Ports:
clk  input  1  rising-edge clock
clr  input  1  synchronous reset, active-high
en  input  1  count enable; gates inc and dec only
inc  input  1  increment request, sampled when en=1
dec  input  1  decrement request, sampled when en=1
load  input  1  parallel load strobe
load_val  input  4*DIGITS  BCD load value; digit i is in bits [4i+3:4i], digit 0 is least significant
count  output  4*DIGITS  current BCD value, same digit packing as load_val
at_max  output  1  high when every digit of count is 9
at_min  output  1  high when count is 0
ovf  output  1  one-cycle pulse on an increment attempted at max
unf  output  1  one-cycle pulse on a decrement attempted at min

Behaviour:
- Interface: one clock, clk. Reset clr is synchronous and active-high.
- Reset: while clr=1 at a rising edge, count=0, ovf=0, unf=0. at_max=0 and at_min=1 follow from count.
- Priority per edge: clr > load > (en & inc & ~dec) > (en & dec & ~inc) > hold.
- inc and dec both high with en=1: hold. No ovf/unf.
- en=0: inc and dec are ignored and count holds. load still takes effect.
- Load: count <= load_val on the next edge. Any digit above 9 is clamped to 9 per digit. Example: load_val 0x3C for DIGITS=2 loads 0x39. Load never raises ovf/unf.
- Increment: ripple BCD add of 1. Digit 0 goes to digit+1 if below 9. Otherwise it becomes 0 and carries to the next digit, repeated up the chain. Latency is 1 cycle; count is registered.
- Increment at max (all digits 9):
  - WRAP=0: count holds and ovf=1 for one cycle.
  - WRAP=1: count becomes 0 and ovf=1 for one cycle.
- Decrement: ripple BCD subtract of 1. A digit of 0 becomes 9 and borrows from the next digit.
- Decrement at 0:
  - WRAP=0: count holds and unf=1 for one cycle.
  - WRAP=1: count becomes 99..9 and unf=1 for one cycle.
- ovf and unf are registered. Each is high only for the cycle after the offending request edge. They are cleared on every other edge, including when an inc/dec is held high across repeated limit hits: the pulse then re-asserts each cycle.
- at_max and at_min are combinational decodes of the count register. They are valid in the same cycle as count.
- Held inc or dec counts once per clock. There is no edge detection; debouncing and one-shot generation are upstream.
- clr asserted mid-count or coincident with load/inc/dec: clr wins and count goes to 0 on that edge.
- Every digit of count is always in 0..9. No non-BCD state is reachable.

Test Plan:
- Reset then increment: DIGITS=2, WRAP=0; clr=1 for 1 cycle, then en=1, inc=1 for 12 cycles -> count goes 0x00..0x09, 0x10, 0x11, 0x12. at_min=1 only at 0x00. No ovf.
- Saturate limits: DIGITS=2, WRAP=0; load 0x98, then inc for 3 cycles -> 0x99, 0x99, 0x99. ovf pulses on the 2nd and 3rd edges and at_max=1. Then load 0x01 and dec for 3 cycles -> 0x00, 0x00, 0x00 with unf on the 2nd and 3rd edges.
- Wrap mode: DIGITS=3, WRAP=1; load 0x999, inc 1 cycle -> 0x000 with ovf=1 for exactly one cycle. Then dec 1 cycle -> 0x999 with unf=1.
- Borrow/carry chain: DIGITS=4; load 0x1000, dec -> 0x0999. Then inc -> 0x1000. at_max and at_min stay 0 throughout.
- Controls and priority:
  - inc=dec=1 with en=1 -> count holds, no pulses.
  - en=0 with inc=1 -> holds.
  - load=1 with inc=1 and load_val 0x4F (DIGITS=2) -> 0x49.
  - clr=1 with load=1 -> 0x00.
- Reset mid-run: counting up at 0x57, assert clr for one edge -> 0x00 on that edge. Counting resumes from 0x01 on the next inc edge.
